// File: rtl/psum_porta_arbiter.sv
// rtl/psum_porta_arbiter.sv - psum SRAM port-A arbiter between the systolic controller and the psum loader
// Loader writes cannot stall, so they are skid-buffered per bank while the controller owns the port.
module psum_porta_arbiter #(
  parameter int NUM_BANK   = 8,
  parameter int ADDR_W     = 15,
  parameter int PSUM_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RSTb,
  input  logic                       ctrl_req,
  output logic                       ctrl_gnt,
  input  logic [NUM_BANK-1:0]        ctrl_we,
  input  logic [NUM_BANK-1:0]        ctrl_en,
  input  logic [NUM_BANK*ADDR_W-1:0] ctrl_addr,
  input  logic [NUM_BANK*PSUM_W-1:0] ctrl_din,
  input  logic [NUM_BANK-1:0]        ld_we,
  input  logic [NUM_BANK-1:0]        ld_en,
  input  logic [NUM_BANK*ADDR_W-1:0] ld_addr,
  input  logic [NUM_BANK*PSUM_W-1:0] ld_din,
  output logic [NUM_BANK-1:0]        sram_we_a,
  output logic [NUM_BANK-1:0]        sram_en_a,
  output logic [NUM_BANK*ADDR_W-1:0] sram_addr_a,
  output logic [NUM_BANK*PSUM_W-1:0] sram_din_a,
  output logic [NUM_BANK-1:0]        fifo_empty,
  output logic                       overflow,
  input  logic                       overflow_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + PSUM_W;

  typedef enum logic [1:0] {
    LOADER     = 2'd0,
    WAIT_EMPTY = 2'd1,
    CTRL       = 2'd2
  } state_t;

  state_t state;

  logic [ENT_W-1:0] fifo_mem [NUM_BANK][FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr   [NUM_BANK];
  logic [PTR_W-1:0] wr_ptr   [NUM_BANK];
  logic [CNT_W-1:0] count    [NUM_BANK];

  logic [NUM_BANK-1:0] ld_wr;
  logic [NUM_BANK-1:0] push;
  logic [NUM_BANK-1:0] pop;
  logic [NUM_BANK-1:0] drop;
  logic [NUM_BANK-1:0] accept;
  logic                all_empty;

  always_comb begin
    fifo_empty = '0;
    for (int i = 0; i < NUM_BANK; i++) begin
      fifo_empty[i] = (count[i] == '0);
    end
  end

  assign all_empty = &fifo_empty;

  // The FIFO only absorbs loader writes while the controller owns the port or older data is queued.
  always_comb begin
    ld_wr  = ld_en & ld_we;
    push   = '0;
    pop    = '0;
    drop   = '0;
    accept = '0;
    for (int i = 0; i < NUM_BANK; i++) begin
      if (state == CTRL) begin
        push[i] = ld_wr[i];
      end else if (count[i] != '0) begin
        pop[i]  = 1'b1;
        push[i] = ld_wr[i];
      end
      drop[i]   = push[i] && !pop[i] && (count[i] == CNT_W'(FIFO_DEPTH));
      accept[i] = push[i] && !drop[i];
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_BANK; i++) begin
      if (accept[i]) begin
        fifo_mem[i][wr_ptr[i]] <= {ld_addr[i*ADDR_W +: ADDR_W], ld_din[i*PSUM_W +: PSUM_W]};
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      for (int i = 0; i < NUM_BANK; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BANK; i++) begin
        if (accept[i]) begin
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        end
        count[i] <= count[i] + CNT_W'(accept[i]) - CNT_W'(pop[i]);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      sram_we_a   <= '0;
      sram_en_a   <= '0;
      sram_addr_a <= '0;
      sram_din_a  <= '0;
    end else begin
      for (int i = 0; i < NUM_BANK; i++) begin
        if (state == CTRL) begin
          sram_we_a[i]                   <= ctrl_we[i];
          sram_en_a[i]                   <= ctrl_en[i];
          sram_addr_a[i*ADDR_W +: ADDR_W] <= ctrl_addr[i*ADDR_W +: ADDR_W];
          sram_din_a[i*PSUM_W +: PSUM_W]  <= ctrl_din[i*PSUM_W +: PSUM_W];
        end else if (pop[i]) begin
          sram_we_a[i]                   <= 1'b1;
          sram_en_a[i]                   <= 1'b1;
          sram_addr_a[i*ADDR_W +: ADDR_W] <= fifo_mem[i][rd_ptr[i]][ENT_W-1:PSUM_W];
          sram_din_a[i*PSUM_W +: PSUM_W]  <= fifo_mem[i][rd_ptr[i]][PSUM_W-1:0];
        end else begin
          sram_we_a[i]                   <= ld_wr[i];
          sram_en_a[i]                   <= ld_wr[i];
          sram_addr_a[i*ADDR_W +: ADDR_W] <= ld_addr[i*ADDR_W +: ADDR_W];
          sram_din_a[i*PSUM_W +: PSUM_W]  <= ld_din[i*PSUM_W +: PSUM_W];
        end
      end
    end
  end

  // Grant mirrors the CTRL state; it is set together with the state so it is glitch-free.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state    <= LOADER;
      ctrl_gnt <= 1'b0;
    end else begin
      case (state)
        LOADER: begin
          if (ctrl_req) begin
            if (all_empty) begin
              state    <= CTRL;
              ctrl_gnt <= 1'b1;
            end else begin
              state <= WAIT_EMPTY;
            end
          end
        end
        WAIT_EMPTY: begin
          if (!ctrl_req) begin
            state <= LOADER;
          end else if (all_empty) begin
            state    <= CTRL;
            ctrl_gnt <= 1'b1;
          end
        end
        CTRL: begin
          if (!ctrl_req) begin
            state    <= LOADER;
            ctrl_gnt <= 1'b0;
          end
        end
        default: begin
          state    <= LOADER;
          ctrl_gnt <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      overflow <= 1'b0;
    end else if (|drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: doc/psum_porta_arbiter.md
Name: psum_porta_arbiter

Overview:
Arbitrates the per-bank A (write) port of the psum SRAM banks between the systolic controller and the psum loader. It replaces the bare select-mux. Loader writes come from the free-running systolic output and can never be stalled, so they are buffered in a small per-bank FIFO while the controller owns the port. The controller takes the port through a req/gnt handshake.

Parameters:
NUM_BANK, 8 (= `PE_COL), number of psum banks
ADDR_W, 15 (= `BIT_ADDR), bank address width
PSUM_W, 32 (= `BIT_PSUM), psum data width
FIFO_DEPTH, 4, loader skid FIFO entries per bank (power of 2, >=2)

Ports:
CLK  in  1  clock, all state on rising edge
RSTb  in  1  asynchronous active-low reset
ctrl_req  in  1  controller requests exclusive port-A ownership (level)
ctrl_gnt  out  1  registered grant; controller may drive ctrl_* only while high
ctrl_we  in  NUM_BANK  controller write enable per bank
ctrl_en  in  NUM_BANK  controller enable per bank
ctrl_addr  in  NUM_BANK*ADDR_W  controller address, bank i at [i*ADDR_W +: ADDR_W]
ctrl_din  in  NUM_BANK*PSUM_W  controller write data
ld_we  in  NUM_BANK  loader write enable
ld_en  in  NUM_BANK  loader enable
ld_addr  in  NUM_BANK*ADDR_W  loader address
ld_din  in  NUM_BANK*PSUM_W  loader write data
sram_we_a  out  NUM_BANK  to psum SRAM port A
sram_en_a  out  NUM_BANK  to psum SRAM port A
sram_addr_a  out  NUM_BANK*ADDR_W  to psum SRAM port A
sram_din_a  out  NUM_BANK*PSUM_W  to psum SRAM port A
fifo_empty  out  NUM_BANK  per-bank FIFO empty flag
overflow  out  1  sticky flag: a loader write was dropped
overflow_clr  in  1  synchronous clear of overflow

Behaviour:
- Reset (RSTb=0, async): state=LOADER, ctrl_gnt=0, all FIFOs empty (fifo_empty all 1s), overflow=0, all sram_*_a outputs 0.
- Loader write = ld_en[i]&ld_we[i]. Loader en without we is ignored and never enqueued.
- All sram_*_a outputs are registered. Latency is exactly 1 cycle from the selected source to the SRAM pins.
- FSM states: LOADER, WAIT_EMPTY, CTRL.
  - LOADER: if ctrl_req=1 and all FIFOs are empty, go to CTRL. If ctrl_req=1 and any FIFO is non-empty, go to WAIT_EMPTY.
  - WAIT_EMPTY: if ctrl_req=0, go to LOADER. Otherwise, once all FIFOs are empty (registered flags), go to CTRL.
  - CTRL: if ctrl_req=0, go to LOADER.
- ctrl_gnt=1 exactly when state==CTRL. It rises the cycle after entry to CTRL and falls the cycle after ctrl_req drops.
- Per-bank source select, evaluated each cycle and registered to the outputs:
  - state==CTRL: drive ctrl_* of bank i unchanged. A loader write pushes into FIFO i; there is no pop.
  - state!=CTRL, FIFO i non-empty: drive the FIFO head (we=en=1) and pop. A loader write pushes in the same cycle. Per-bank order is preserved.
  - state!=CTRL, FIFO i empty: drive the loader write directly (bypass). Do not enqueue. Drive we=en=0 if there is no loader write.
- ctrl_* inputs are ignored outside CTRL.
- Push to a full FIFO with no pop that cycle: the write is dropped and overflow is set. Push and pop in the same cycle on a full FIFO is legal, and the level is unchanged.
- Overflow set has priority over overflow_clr in the same cycle.
- ctrl_req may toggle in any state. Deassertion during WAIT_EMPTY returns to LOADER with no grant pulse.
- Reset mid-operation: FIFO contents are discarded and the outputs deassert immediately.
- Banks are fully independent except for the shared FSM and grant.
- fifo_empty is driven directly from the per-bank FIFO count registers.

Test Plan:
- Reset, then idle -> ctrl_gnt=0, overflow=0, fifo_empty=8'hFF, sram_en_a=0.
- Loader bypass: ld bank0 addr=5 din=100 at cycle t -> sram_en_a[0]=sram_we_a[0]=1, addr=5, din=100 at t+1. FIFO stays empty.
- Grant with empty FIFOs: ctrl_req=1 at t -> ctrl_gnt=1 at t+1. A ctrl write to bank3 addr=7 din=0 issued at t+1 appears at the SRAM at t+2. Drop ctrl_req -> gnt=0 the next cycle.
- Buffering during CTRL: three loader writes to bank1 (addr 1,2,3 / din 10,20,30) while granted -> fifo_empty[1]=0. After the req drop, the SRAM sees addr 1,2,3 in order on consecutive cycles, then the FIFO is empty.
- WAIT_EMPTY: bank2 holds 2 entries when ctrl_req rises -> gnt stays 0 for 2 drain cycles, then rises. A req drop during the wait returns to LOADER with no gnt pulse.
- Overflow: 5 loader writes to bank0 while granted (depth 4) -> the 5th is dropped and overflow=1. The drain delivers only 4. overflow_clr=1 -> overflow=0 the next cycle.
